// File: rtl/gate_response_checker_if.sv
// Bus between the gate response checker and the gate under test / controlling bench.
interface gate_response_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_idx;

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/gate_response_checker.sv
// Exhaustive truth-table sweeper: drives every input vector of a small
// combinational gate in ascending order, waits SETTLE cycles, samples the
// gate output and compares it with the expected table.
module gate_response_checker #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b1000
) (
  input  logic                    clk,
  input  logic                    rst,
  gate_response_checker_if.slave  bus
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            mismatch;

  // State register and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  // Next-state and result update: settle each vector, then sample and score it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    mismatch = (bus.dut_out != EXPECT[idx_q]);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          stim_d  = idx_q + 1'b1;
          state_d = S_DRIVE;
        end else begin
          // Terminal vector: pass must reflect this vector's result too.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          stim_d  = '0;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stim             = stim_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (2-input AND default and a
// 3-input AND with longer settle), behavioural gate models, scoreboard queues.
module tb_gate_response_checker;

  localparam int         NA = 2;
  localparam int         SA = 1;
  localparam logic [3:0] EA = 4'b1000;
  localparam int         NB = 3;
  localparam int         SB = 2;
  localparam logic [7:0] EB = 8'h80;

  localparam int M_AND = 0, M_ZERO = 1, M_OR = 2, M_NAND = 3, M_FAULT5 = 4, M_TABLE = 5;

  typedef struct {
    int err;
    int ffv;
    int ffi;
    int pass;
    int lat;
    int stim_bad;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_response_checker_if #(.N_IN(NA)) ifa ();
  gate_response_checker_if #(.N_IN(NB)) ifb ();

  gate_response_checker #(.N_IN(NA), .SETTLE(SA), .EXPECT(EA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  gate_response_checker #(.N_IN(NB), .SETTLE(SB), .EXPECT(EB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int          mode_a, mode_b;
  logic [63:0] tbl_a, tbl_b;
  int          total = 0;
  int          bad = 0;
  res_t        qa[$];
  res_t        qb[$];

  // Behavioural gate under test.
  function automatic logic gate(int mode, int s, int n, logic [63:0] tbl);
    int all1;
    all1 = (1 << n) - 1;
    case (mode)
      M_AND:    return s == all1;
      M_ZERO:   return 1'b0;
      M_OR:     return s != 0;
      M_NAND:   return s != all1;
      M_FAULT5: return (s == all1) || (s == 5);
      M_TABLE:  return tbl[s];
      default:  return 1'b0;
    endcase
  endfunction

  always_comb ifa.dut_out = gate(mode_a, int'(ifa.stim), NA, tbl_a);
  always_comb ifb.dut_out = gate(mode_b, int'(ifb.stim), NB, tbl_b);

  // Reference: score the whole truth table at once.
  function automatic res_t model(int n, int s, logic [63:0] ex, int mode, logic [63:0] tbl);
    res_t r;
    r.err = 0; r.ffv = 0; r.ffi = 0; r.stim_bad = 0;
    for (int i = 0; i < (1 << n); i++) begin
      if (gate(mode, i, n, tbl) != ex[i]) begin
        r.err++;
        if (r.ffv == 0) begin
          r.ffv = 1;
          r.ffi = i;
        end
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    r.lat  = (1 << n) * (s + 1);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_res(string tag, res_t a, res_t e);
    chk({tag, "_err_count"}, a.err, e.err);
    chk({tag, "_ff_valid"}, a.ffv, e.ffv);
    chk({tag, "_ff_idx"}, a.ffi, e.ffi);
    chk({tag, "_pass"}, a.pass, e.pass);
    chk({tag, "_latency"}, a.lat, e.lat);
    chk({tag, "_stim_seq_bad"}, a.stim_bad, e.stim_bad);
  endtask

  // Monitor A: tracks stim ordering/latency and scores results when done rises.
  int busy_cnt_a = 0, stim_bad_a = 0;
  logic busy_prev_a = 1'b0, done_prev_a = 1'b0;
  always @(negedge clk) begin
    res_t act, e;
    if (rst) begin
      busy_cnt_a = 0; stim_bad_a = 0; busy_prev_a = 1'b0; done_prev_a = 1'b0;
    end else begin
      if (ifa.busy && !busy_prev_a) begin
        busy_cnt_a = 0;
        stim_bad_a = 0;
      end
      if (ifa.busy) begin
        if (int'(ifa.stim) != busy_cnt_a / (SA + 1)) stim_bad_a = 1;
        busy_cnt_a++;
      end
      if (ifa.done && !done_prev_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_done", 1, 0);
        end else begin
          e = qa.pop_front();
          act.err = int'(ifa.err_count); act.ffv = int'(ifa.first_fail_valid);
          act.ffi = int'(ifa.first_fail_idx); act.pass = int'(ifa.pass);
          act.lat = busy_cnt_a; act.stim_bad = stim_bad_a;
          cmp_res("a", act, e);
          chk("a_stim_zero_at_done", int'(ifa.stim), 0);
        end
      end
      busy_prev_a = ifa.busy;
      done_prev_a = ifa.done;
    end
  end

  // Monitor B: same scoring for the 3-input instance.
  int busy_cnt_b = 0, stim_bad_b = 0;
  logic busy_prev_b = 1'b0, done_prev_b = 1'b0;
  always @(negedge clk) begin
    res_t act, e;
    if (rst) begin
      busy_cnt_b = 0; stim_bad_b = 0; busy_prev_b = 1'b0; done_prev_b = 1'b0;
    end else begin
      if (ifb.busy && !busy_prev_b) begin
        busy_cnt_b = 0;
        stim_bad_b = 0;
      end
      if (ifb.busy) begin
        if (int'(ifb.stim) != busy_cnt_b / (SB + 1)) stim_bad_b = 1;
        busy_cnt_b++;
      end
      if (ifb.done && !done_prev_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          e = qb.pop_front();
          act.err = int'(ifb.err_count); act.ffv = int'(ifb.first_fail_valid);
          act.ffi = int'(ifb.first_fail_idx); act.pass = int'(ifb.pass);
          act.lat = busy_cnt_b; act.stim_bad = stim_bad_b;
          cmp_res("b", act, e);
          chk("b_stim_zero_at_done", int'(ifb.stim), 0);
        end
      end
      busy_prev_b = ifb.busy;
      done_prev_b = ifb.done;
    end
  end

  task automatic pulse_a();
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk); ifb.start = 1'b1;
    @(negedge clk); ifb.start = 1'b0;
  endtask

  task automatic wait_a(int budget);
    int n = 0;
    while (!ifa.done && n < budget) begin @(negedge clk); n++; end
    if (!ifa.done) chk("a_done_timeout", 0, 1);
    chk("a_busy_low_at_done", int'(ifa.busy), 0);
  endtask

  task automatic wait_b(int budget);
    int n = 0;
    while (!ifb.done && n < budget) begin @(negedge clk); n++; end
    if (!ifb.done) chk("b_done_timeout", 0, 1);
    chk("b_busy_low_at_done", int'(ifb.busy), 0);
  endtask

  task automatic run_a(int mode, logic [63:0] tbl);
    mode_a = mode; tbl_a = tbl;
    qa.push_back(model(NA, SA, 64'(EA), mode, tbl));
    pulse_a();
    wait_a(200);
  endtask

  task automatic run_b(int mode, logic [63:0] tbl);
    mode_b = mode; tbl_b = tbl;
    qb.push_back(model(NB, SB, 64'(EB), mode, tbl));
    pulse_b();
    wait_b(400);
  endtask

  task automatic chk_idle_a(string tag);
    chk({tag, "_stim"}, int'(ifa.stim), 0);
    chk({tag, "_busy"}, int'(ifa.busy), 0);
    chk({tag, "_done"}, int'(ifa.done), 0);
    chk({tag, "_pass"}, int'(ifa.pass), 0);
    chk({tag, "_err"}, int'(ifa.err_count), 0);
    chk({tag, "_ffv"}, int'(ifa.first_fail_valid), 0);
    chk({tag, "_ffi"}, int'(ifa.first_fail_idx), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    mode_a = M_AND; mode_b = M_AND; tbl_a = '0; tbl_b = '0;
    repeat (3) @(negedge clk);
    chk_idle_a("reset_a");
    chk("reset_b_busy", int'(ifb.busy), 0);
    chk("reset_b_err", int'(ifb.err_count), 0);
    rst = 1'b0;

    // Directed sweeps on the 2-input AND checker.
    run_a(M_AND, '0);
    run_a(M_ZERO, '0);
    run_a(M_OR, '0);
    run_a(M_NAND, '0);

    // Restart from DONE with a good gate: results clear at the start edge.
    mode_a = M_AND;
    qa.push_back(model(NA, SA, 64'(EA), M_AND, '0));
    pulse_a();
    chk("restart_err_cleared", int'(ifa.err_count), 0);
    chk("restart_ffv_cleared", int'(ifa.first_fail_valid), 0);
    chk("restart_ffi_cleared", int'(ifa.first_fail_idx), 0);
    chk("restart_done_cleared", int'(ifa.done), 0);
    chk("restart_busy", int'(ifa.busy), 1);
    wait_a(200);

    // Start ignored while busy, then reset aborts the sweep mid-way.
    mode_a = M_NAND;
    pulse_a();                       // now just past edge k
    @(negedge clk);                  // past k+1
    @(negedge clk); ifa.start = 1'b1; // start sampled at k+3
    @(negedge clk); ifa.start = 1'b0;
    chk("busy_start_ignored_stim_k3", int'(ifa.stim), 1);
    @(negedge clk);
    chk("busy_start_ignored_stim_k4", int'(ifa.stim), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_a("midsweep_rst");
    repeat (12) @(negedge clk);
    chk("after_rst_quiet_busy", int'(ifa.busy), 0);
    chk("after_rst_quiet_stim", int'(ifa.stim), 0);
    chk("after_rst_quiet_done", int'(ifa.done), 0);

    // rst and start together: reset wins.
    @(negedge clk); rst = 1'b1; ifa.start = 1'b1;
    @(negedge clk); rst = 1'b0; ifa.start = 1'b0;
    chk("rst_beats_start_busy", int'(ifa.busy), 0);
    repeat (2) @(negedge clk);
    chk("rst_beats_start_still_idle", int'(ifa.busy), 0);

    // Random truth tables on the 2-input checker.
    for (int r = 0; r < 5; r++) run_a(M_TABLE, 64'($urandom));

    // 3-input AND with longer settle, then a single faulty vector.
    run_b(M_AND, '0);
    run_b(M_FAULT5, '0);
    for (int r = 0; r < 4; r++) run_b(M_TABLE, {32'($urandom), 32'($urandom)});

    repeat (3) @(negedge clk);
    chk("sb_a_empty", qa.size(), 0);
    chk("sb_b_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
